// File: rtl/cnn_pkg.sv
// Shared CNN accelerator constants and the output saturation helper used by
// both the pooling stage and the memory writer.
package cnn_pkg;

   localparam int IMG_W     = 28;
   localparam int CONV_W    = 26;
   localparam int POOL_W    = 13;
   localparam int SAT_IN_W  = 32;
   localparam int SAT_OUT_W = 8;

   // Clamp a signed activation into the unsigned pixel range.
   function automatic logic [SAT_OUT_W-1:0] sat_u(input logic signed [SAT_IN_W-1:0] m);
      logic [SAT_OUT_W-1:0] r;
      if (m[SAT_IN_W-1]) begin
         r = '0;
      end else if (|m[SAT_IN_W-2:SAT_OUT_W]) begin
         r = '1;
      end else begin
         r = m[SAT_OUT_W-1:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/maxpool2x2_stream_row_buffer.sv
// One-row scratch of horizontal pair maxima written on even rows and read
// back on odd rows; one write port, one combinational read port.
module pool_row_buffer #(
   parameter int DEPTH = 13,
   parameter int WIDTH = 32,
   parameter int AW    = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];

   // Next-state of the storage array: single write per cycle.
   always_comb begin
      mem_d = mem_q;
      if (we_i) begin
         mem_d[waddr_i] = wdata_i;
      end else begin
         mem_d = mem_q;
      end
   end

   // Storage registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q <= '{default: '0};
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 stride-2 max-pool with saturation to unsigned pixels.
// Odd trailing columns/rows are consumed and discarded.
module maxpool2x2_stream
   import cnn_pkg::*;
#(
   parameter int DATA_WIDTH = SAT_IN_W,
   parameter int OUT_WIDTH  = SAT_OUT_W,
   parameter int ROW_LEN    = CONV_W,
   parameter int NUM_ROWS   = CONV_W
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  frame_start_i,
   input  logic [DATA_WIDTH-1:0] in_data_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   output logic [OUT_WIDTH-1:0]  out_data_o,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic                  out_last_o,
   output logic                  frame_done_o
);

   localparam int PW = ROW_LEN / 2;
   localparam int PH = NUM_ROWS / 2;
   localparam int CW = $clog2(ROW_LEN + 1);
   localparam int RW = $clog2(NUM_ROWS + 1);
   localparam int AW = (PW > 1) ? $clog2(PW) : 1;

   localparam logic [CW-1:0] COL_LAST    = CW'(ROW_LEN - 1);
   localparam logic [RW-1:0] ROW_LAST    = RW'(NUM_ROWS - 1);
   localparam logic [CW-1:0] COL_WIN_END = CW'(2 * PW);
   localparam logic [RW-1:0] ROW_WIN_END = RW'(2 * PH);
   localparam logic [CW-1:0] COL_FINAL   = CW'(2 * PW - 1);
   localparam logic [RW-1:0] ROW_FINAL   = RW'(2 * PH - 1);

   logic [CW-1:0]                col_q, col_d;
   logic [RW-1:0]                row_q, row_d;
   logic signed [DATA_WIDTH-1:0] pair_q, pair_d;
   logic                         out_valid_q, out_valid_d;
   logic [OUT_WIDTH-1:0]         out_data_q, out_data_d;
   logic                         out_last_q, out_last_d;

   logic                         in_hs_s, out_hs_s, in_win_s, wr_en_s, load_s;
   logic [AW-1:0]                rb_idx_s;
   logic [DATA_WIDTH-1:0]        rb_rdata_s;
   logic signed [DATA_WIDTH-1:0] sample_s, rb_val_s, pair_max_s, win_max_s;

   // frame_start_i wins over both handshakes so an aborted beat is dropped.
   assign in_ready_o = !out_valid_q || out_ready_i;
   assign in_hs_s    = in_valid_i && in_ready_o && !frame_start_i;
   assign out_hs_s   = out_valid_q && out_ready_i && !frame_start_i;
   assign in_win_s   = (col_q < COL_WIN_END) && (row_q < ROW_WIN_END);
   assign wr_en_s    = in_hs_s && in_win_s && col_q[0] && !row_q[0];
   assign load_s     = in_hs_s && in_win_s && col_q[0] && row_q[0];
   assign rb_idx_s   = col_q[AW:1];

   assign sample_s   = signed'(in_data_i);
   assign rb_val_s   = signed'(rb_rdata_s);
   assign pair_max_s = (sample_s > pair_q) ? sample_s : pair_q;
   assign win_max_s  = (rb_val_s > pair_max_s) ? rb_val_s : pair_max_s;

   pool_row_buffer #(
      .DEPTH (PW),
      .WIDTH (DATA_WIDTH),
      .AW    (AW)
   ) u_row_buffer (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .we_i    (wr_en_s),
      .waddr_i (rb_idx_s),
      .wdata_i (pair_max_s),
      .raddr_i (rb_idx_s),
      .rdata_o (rb_rdata_s)
   );

   // Raster position and the even-column pair holder.
   always_comb begin
      col_d  = col_q;
      row_d  = row_q;
      pair_d = pair_q;
      if (frame_start_i) begin
         col_d  = '0;
         row_d  = '0;
         pair_d = '0;
      end else if (in_hs_s) begin
         if (!col_q[0]) begin
            pair_d = sample_s;
         end else begin
            pair_d = pair_q;
         end
         if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
         end else begin
            col_d = col_q + CW'(1);
         end
      end else begin
         col_d = col_q;
      end
   end

   // Single-entry output register; a load during a drain keeps it full.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      if (frame_start_i) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end else if (load_s) begin
         out_valid_d = 1'b1;
         out_data_d  = sat_u(win_max_s);
         out_last_d  = (row_q == ROW_FINAL) && (col_q == COL_FINAL);
      end else if (out_hs_s) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // State registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         col_q       <= '0;
         row_q       <= '0;
         pair_q      <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
      end else begin
         col_q       <= col_d;
         row_q       <= row_d;
         pair_q      <= pair_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
      end
   end

   assign out_valid_o  = out_valid_q;
   assign out_data_o   = out_data_q;
   assign out_last_o   = out_last_q;
   assign frame_done_o = out_hs_s && out_last_q;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Self-checking bench: three pool instances (26x26, 4x4, 5x5) checked against
// a window-max reference model, a vector table, and hand-written corner cases.
module tb_maxpool2x2_stream;

   logic             clk = 1'b0;
   logic             rst_ni;
   logic [2:0][31:0] sd;
   logic [2:0]       sv, srdy, ordy, ov, ol, fd, fs;
   logic [2:0][7:0]  od;

   int        total = 0;
   int        bad = 0;
   int        fd_cnt[3];
   logic [8:0] gq[3][$];
   int        frm[676];
   bit        done;

   typedef struct {
      int         w[4];
      logic [7:0] exp;
   } vec_t;
   vec_t tbl[6];

   always #5 clk = ~clk;

   genvar g;
   generate
      for (g = 0; g < 3; g++) begin : g_dut
         localparam int L = (g == 0) ? 26 : ((g == 1) ? 4 : 5);
         maxpool2x2_stream #(
            .DATA_WIDTH (32), .OUT_WIDTH (8), .ROW_LEN (L), .NUM_ROWS (L)
         ) u_dut (
            .clk_i         (clk),
            .rst_ni        (rst_ni),
            .frame_start_i (fs[g]),
            .in_data_i     (sd[g]),
            .in_valid_i    (sv[g]),
            .in_ready_o    (srdy[g]),
            .out_data_o    (od[g]),
            .out_valid_o   (ov[g]),
            .out_ready_i   (ordy[g]),
            .out_last_o    (ol[g]),
            .frame_done_o  (fd[g])
         );
      end
   endgenerate

   // Output monitor: inputs only change just after posedge, so negedge values hold for the edge.
   always @(negedge clk) begin
      if (rst_ni) begin
         for (int i = 0; i < 3; i++) begin
            if (ov[i] && ordy[i] && !fs[i]) gq[i].push_back({ol[i], od[i]});
            if (fd[i]) fd_cnt[i]++;
         end
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int mx(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic logic [7:0] sat8(input int m);
      if (m < 0) return 8'd0;
      else if (m > 255) return 8'd255;
      else return m[7:0];
   endfunction

   function automatic int rnd_sample();
      case ($urandom_range(0, 3))
         0: return int'($urandom_range(0, 300)) - 40;
         1: return int'($urandom);
         2: return -int'($urandom_range(0, 100000));
         default: return int'($urandom_range(240, 270));
      endcase
   endfunction

   task automatic clear(input int i);
      gq[i].delete();
      fd_cnt[i] = 0;
   endtask

   task automatic send(input int i, input int d);
      int n;
      n = 0;
      sd[i] = d;
      sv[i] = 1'b1;
      @(negedge clk);
      while (!srdy[i] && n < 300) begin
         n++;
         @(negedge clk);
      end
      if (!srdy[i]) begin
         total++;
         bad++;
         $display("FAIL send_timeout: inst %0d in_ready stuck 0", i);
      end
      @(posedge clk);
      #1;
      sv[i] = 1'b0;
   endtask

   task automatic send_frame(input int i, input int len);
      for (int k = 0; k < len * len; k++) send(i, frm[k]);
   endtask

   task automatic drain();
      repeat (6) @(posedge clk);
      #1;
   endtask

   // Reference: every 2x2 window max of frm, saturated, raster order.
   task automatic check_frame(input int i, input int len, input string name);
      int p, m, idx;
      logic [8:0] v;
      p = len / 2;
      chk({name, "_count"}, gq[i].size(), p * p);
      for (int pr = 0; pr < p; pr++) begin
         for (int pc = 0; pc < p; pc++) begin
            idx = pr * p + pc;
            m = mx(mx(frm[2*pr*len + 2*pc], frm[2*pr*len + 2*pc + 1]),
                   mx(frm[(2*pr+1)*len + 2*pc], frm[(2*pr+1)*len + 2*pc + 1]));
            if (idx < gq[i].size()) begin
               v = gq[i][idx];
               chk({name, "_data"}, v[7:0], sat8(m));
               chk({name, "_last"}, v[8], (idx == p * p - 1) ? 1 : 0);
            end
         end
      end
      chk({name, "_frame_done"}, fd_cnt[i], 1);
   endtask

   initial begin
      logic [8:0] v;
      int         exp_ramp[4];
      int         exp_odd[4];
      logic [7:0] held;

      exp_ramp = '{5, 7, 13, 15};
      exp_odd  = '{6, 8, 16, 18};
      tbl[0] = '{w: '{-5, -9, -1, -7},     exp: 8'd0};
      tbl[1] = '{w: '{300, 2, 3, 4},       exp: 8'd255};
      tbl[2] = '{w: '{200, 201, 17, 0},    exp: 8'd201};
      tbl[3] = '{w: '{255, -1, 0, 254},    exp: 8'd255};
      tbl[4] = '{w: '{256, -300, 1, 2},    exp: 8'd255};
      tbl[5] = '{w: '{-70000, 3, 99, -2},  exp: 8'd99};

      rst_ni = 1'b0;
      sv = '0; sd = '0; fs = '0; ordy = '1;
      for (int i = 0; i < 3; i++) fd_cnt[i] = 0;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("rst_valid", ov[i], 0);
         chk("rst_data", od[i], 0);
         chk("rst_last", ol[i], 0);
         chk("rst_done", fd[i], 0);
      end
      chk("rst_in_ready", srdy[0], 1);
      rst_ni = 1'b1;
      @(posedge clk);
      #1;

      // Ramp 4x4 with a latency check on the first window.
      for (int k = 0; k < 16; k++) frm[k] = k;
      clear(1);
      for (int k = 0; k < 16; k++) begin
         send(1, frm[k]);
         if (k == 4) chk("lat_before", ov[1], 0);
         if (k == 5) begin
            chk("lat_valid", ov[1], 1);
            chk("lat_data", od[1], 5);
         end
      end
      drain();
      check_frame(1, 4, "ramp");
      for (int k = 0; k < 4; k++) if (k < gq[1].size()) begin
         v = gq[1][k];
         chk("ramp_const", v[7:0], exp_ramp[k]);
      end

      // Odd geometry 5x5.
      for (int k = 0; k < 25; k++) frm[k] = k;
      clear(2);
      send_frame(2, 5);
      drain();
      check_frame(2, 5, "odd");
      for (int k = 0; k < 4; k++) if (k < gq[2].size()) begin
         v = gq[2][k];
         chk("odd_const", v[7:0], exp_odd[k]);
      end

      // Saturation table: each window placed top-left of a zero 4x4 frame.
      for (int t = 0; t < 6; t++) begin
         for (int k = 0; k < 16; k++) frm[k] = 0;
         frm[0] = tbl[t].w[0]; frm[1] = tbl[t].w[1];
         frm[4] = tbl[t].w[2]; frm[5] = tbl[t].w[3];
         clear(1);
         send_frame(1, 4);
         drain();
         chk("tbl_count", gq[1].size(), 4);
         if (gq[1].size() > 0) begin
            v = gq[1][0];
            chk("tbl_sat", v[7:0], tbl[t].exp);
         end
      end

      // Backpressure on the 26x26 instance, then random ready.
      for (int k = 0; k < 676; k++) frm[k] = rnd_sample();
      clear(0);
      ordy[0] = 1'b0;
      for (int k = 0; k < 28; k++) send(0, frm[k]);
      held = sat8(mx(mx(frm[0], frm[1]), mx(frm[26], frm[27])));
      chk("bp_valid", ov[0], 1);
      chk("bp_in_ready", srdy[0], 0);
      chk("bp_data", od[0], held);
      repeat (5) begin
         @(negedge clk);
         chk("bp_stable", od[0], held);
         chk("bp_stall", srdy[0], 0);
      end
      @(posedge clk);
      #1;
      done = 1'b0;
      fork
         begin
            for (int k = 28; k < 676; k++) send(0, frm[k]);
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1;
               ordy[0] = ($urandom_range(0, 3) != 0);
            end
         end
      join
      ordy[0] = 1'b1;
      drain();
      check_frame(0, 26, "bp");

      // Abort after 30 samples; the concurrent input beat must be dropped.
      for (int k = 0; k < 30; k++) send(0, rnd_sample());
      fs[0] = 1'b1;
      sd[0] = 32'd250;
      sv[0] = 1'b1;
      @(posedge clk);
      #1;
      fs[0] = 1'b0;
      sv[0] = 1'b0;
      chk("abort_valid", ov[0], 0);
      clear(0);
      for (int k = 0; k < 676; k++) frm[k] = rnd_sample();
      send_frame(0, 26);
      drain();
      check_frame(0, 26, "abort");

      // Async reset mid-frame while an output is pending.
      clear(0);
      ordy[0] = 1'b0;
      for (int k = 0; k < 28; k++) send(0, rnd_sample());
      chk("arst_pre_valid", ov[0], 1);
      #2 rst_ni = 1'b0;
      #1;
      chk("arst_valid", ov[0], 0);
      chk("arst_data", od[0], 0);
      #3 rst_ni = 1'b1;
      @(posedge clk);
      #1;
      clear(0);
      ordy[0] = 1'b1;
      for (int k = 0; k < 676; k++) frm[k] = rnd_sample();
      send_frame(0, 26);
      drain();
      check_frame(0, 26, "arst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
